// File: rtl/arith_serial_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the serial FSM state, counter sizing, and the PG borrow-chain equation.
package arith_serial_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int N_DEFAULT     = 4;
  localparam int CNT_W_DEFAULT = cnt_width(N_DEFAULT);

  function automatic logic pg_borrow(input logic p, input logic g, input logic bin);
    return g | (p & bin);
  endfunction

endpackage

// File: rtl/u_serial_pg_rcs_pg_fs.sv
// 1-bit PG full subtractor, purely combinational: d = a - b - bin.
// Zero latency; no flow control of its own, the serial loop around it owns that.
module pg_fs
  import arith_serial_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout,
  output logic p,
  output logic g
);

  // p is "borrow propagates": equal bits pass the incoming borrow through.
  assign p    = ~(a ^ b);
  assign g    = ~a & b;
  assign d    = ~p ^ bin;
  assign bout = pg_borrow(p, g, bin);

endmodule

// File: rtl/u_serial_pg_rcs.sv
// Bit-serial unsigned a-b, LSB first; out_valid rises N cycles after the accepting edge.
// in_ready only in IDLE; result held in DONE for as long as out_ready stays low.
module u_serial_pg_rcs
  import arith_serial_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  d_sr;
  logic [N-1:0]  d_next;
  logic [CW-1:0] cnt;
  logic          borrow;
  logic          d;
  logic          bout;
  logic          p;
  logic          g;

  pg_fs u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout),
    .p    (p),
    .g    (g)
  );

  // New difference bit enters at the top so bit i lands at position i after N shifts.
  assign d_next = N'({d, d_sr} >> 1);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      borrow <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          d_sr   <= d_next;
          borrow <= bout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Final borrow rebuilt from the exported p/g of the last cell evaluation.
            out   <= {pg_borrow(p, g, borrow), d_next};
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u_serial_pg_rcs.sv
// Bench for u_serial_pg_rcs: directed N=4 vectors with literal results plus an
// arithmetic reference model checked every cycle on an N=4 and an N=16 instance.
module tb_u_serial_pg_rcs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- N=4 instance ----------------
  logic       iv4 = 1'b0, or4 = 1'b1, ir4, ov4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [4:0] out4;

  u_serial_pg_rcs #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .out(out4)
  );

  // ---------------- N=16 instance ----------------
  logic        iv16 = 1'b0, or16 = 1'b1, ir16, ov16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [16:0] out16;

  u_serial_pg_rcs #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .out(out16)
  );

  // Reference: phase 0 waiting for operands, 1 busy for N edges, 2 result offered.
  int         m4_phase = 0, m4_left = 0;
  logic [4:0] m4_res = '0, m4_last = '0;
  int          m16_phase = 0, m16_left = 0, m16_ops = 0;
  logic [16:0] m16_res = '0, m16_last = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4_phase = 0; m4_left = 0; m4_last = '0;
    end else begin
      case (m4_phase)
        0: if (iv4) begin
             m4_res   = {1'b0, a4} - {1'b0, b4};
             m4_left  = 4;
             m4_phase = 1;
           end
        1: begin
             m4_left--;
             if (m4_left == 0) begin m4_phase = 2; m4_last = m4_res; end
           end
        default: if (or4) m4_phase = 0;
      endcase
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m16_phase = 0; m16_left = 0; m16_last = '0;
    end else begin
      case (m16_phase)
        0: if (iv16) begin
             m16_res   = {1'b0, a16} - {1'b0, b16};
             m16_left  = 16;
             m16_phase = 1;
           end
        1: begin
             m16_left--;
             if (m16_left == 0) begin m16_phase = 2; m16_last = m16_res; end
           end
        default: if (or16) begin m16_phase = 0; m16_ops++; end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready4",  ir4,  m4_phase == 0);
    chk("out_valid4", ov4,  m4_phase == 2);
    chk("out4",       out4, m4_last);
    chk("in_ready16", ir16, m16_phase == 0);
    chk("out_valid16", ov16, m16_phase == 2);
    chk("out16",      out16, m16_last);
  end

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp,
                      input bit scr, input int hold);
    int n;
    n = 0;
    while (!ir4 && n < 50) begin @(posedge clk); #1; n++; end
    iv4 = 1'b1; a4 = a; b4 = b; or4 = (hold == 0);
    @(posedge clk); #1;
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      if (scr) begin a4 = 4'($urandom); b4 = 4'($urandom); end
      @(posedge clk); #1; n++;
    end
    chk("latency4", n, 4);
    chk("result4", out4, exp);
    for (int k = 0; k < hold; k++) begin
      iv4 = 1'b1; a4 = 4'd1; b4 = 4'd2;
      @(posedge clk); #1;
      chk("hold_valid4", ov4, 1);
      chk("hold_out4",   out4, exp);
      chk("hold_ready4", ir4, 0);
    end
    iv4 = 1'b0; or4 = 1'b1;
    @(posedge clk); #1;
    chk("ready_after4", ir4, 1);
    chk("valid_after4", ov4, 0);
  endtask

  initial begin
    logic [4:0] e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid4", ov4, 0);
    chk("rst_out4",   out4, 0);
    chk("rst_ready4", ir4, 1);
    rst = 1'b0;

    run4(4'd9,  4'd3,  5'b00110, 1'b0, 0);
    run4(4'd3,  4'd5,  5'b11110, 1'b0, 0);
    run4(4'd0,  4'd15, 5'b10001, 1'b0, 0);
    run4(4'd15, 4'd15, 5'b00000, 1'b0, 0);
    run4(4'd0,  4'd0,  5'b00000, 1'b0, 0);
    run4(4'd9,  4'd3,  5'b00110, 1'b1, 0);
    run4(4'd9,  4'd3,  5'b00110, 1'b0, 5);

    // Abort mid-RUN: two bits processed, then an asynchronous reset pulse.
    iv4 = 1'b1; a4 = 4'd12; b4 = 4'd1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_valid4", ov4, 0);
    chk("abort_out4",   out4, 0);
    chk("abort_ready4", ir4, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    run4(4'd7, 4'd2, 5'b00101, 1'b0, 0);

    for (int i = 0; i < 256; i++) begin
      e = {1'b0, 4'(i >> 4)} - {1'b0, 4'(i)};
      run4(4'(i >> 4), 4'(i), e, 1'b0, 0);
    end

    for (int c = 0; c < 20000 && m16_ops < 40; c++) begin
      @(posedge clk); #1;
      iv16 = 1'($urandom_range(0, 1));
      a16  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      b16  = ($urandom_range(0, 7) == 0) ? 16'hffff : 16'($urandom);
      or16 = ($urandom_range(0, 3) != 0);
    end
    chk("ops16_done", m16_ops >= 40, 1);
    iv16 = 1'b0; or16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
